// File: rtl/alu_ctrl_seq.sv
// ALU-control stage between decode and execute: decodes (alu_op, funct) into a
// registered ALU control code with valid/ready flow control and iterative SHL beats.
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 4,
  parameter int CTRL_W     = 4,
  parameter int SHAMT_W    = 3,
  parameter int ITER_SHIFT = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  output logic               shift_step_o,
  output logic               out_last_o,
  output logic               illegal_o,
  output logic               busy_o
);

  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] C_PASS = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] C_ANDR = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] C_ORR  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] C_SHL  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(8);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                shift_step_q, shift_step_d;
  logic                out_last_q, out_last_d;
  logic                illegal_q, illegal_d;

  logic [3:0]          funct_lo;
  logic [CTRL_W-1:0]   dec_ctrl;
  logic                dec_illegal;
  logic                iter_shl;
  logic                accept;

  // Only the low nibble of funct participates in decode.
  assign funct_lo = funct_i[3:0];

  always_comb begin
    dec_ctrl    = C_PASS;
    dec_illegal = 1'b0;
    case (alu_op_i)
      2'b00: begin
        case (funct_lo)
          4'd0:       dec_ctrl = C_ADD;
          4'd1:       dec_ctrl = C_SUB;
          4'd2:       dec_ctrl = C_AND;
          4'd3:       dec_ctrl = C_OR;
          4'd4:       dec_ctrl = C_XOR;
          4'd5:       dec_ctrl = C_ANDR;
          4'd6:       dec_ctrl = C_ORR;
          4'd8, 4'd9: dec_ctrl = C_PASS;
          default:    dec_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        case (funct_lo)
          4'd0:    dec_ctrl = C_ADD;
          4'd1:    dec_ctrl = C_SUB;
          4'd3:    dec_ctrl = C_XOR;
          4'd7:    dec_ctrl = C_SHL;
          default: dec_ctrl = C_PASS;
        endcase
      end
      2'b10:   dec_ctrl = funct_lo[3] ? C_PASS : C_SUB;
      default: dec_ctrl = C_PASS;
    endcase
  end

  assign iter_shl   = (ITER_SHIFT != 0) && (dec_ctrl == C_SHL);
  assign in_ready_o = !flush_i && (state_q == IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    alu_ctrl_d   = alu_ctrl_q;
    shift_step_d = shift_step_q;
    out_last_d   = out_last_q;
    illegal_d    = illegal_q;
    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            out_valid_d  = 1'b1;
            alu_ctrl_d   = dec_ctrl;
            illegal_d    = dec_illegal;
            shift_step_d = 1'b0;
            out_last_d   = 1'b1;
            if (iter_shl) begin
              // shamt==0 is a plain pass-through beat with no shift step.
              if (shamt_i >= SHAMT_W'(2)) begin
                shift_step_d = 1'b1;
                out_last_d   = 1'b0;
                cnt_d        = shamt_i - SHAMT_W'(1);
                state_d      = SHIFT;
              end else if (shamt_i == SHAMT_W'(1)) begin
                shift_step_d = 1'b1;
              end
            end
          end else if (out_ready_i) begin
            out_valid_d = 1'b0;
          end
        end
        SHIFT: begin
          // cnt_q counts beats still to issue after the one being presented.
          if (out_ready_i) begin
            cnt_d        = cnt_q - SHAMT_W'(1);
            shift_step_d = 1'b1;
            out_last_d   = (cnt_q == SHAMT_W'(1));
            if (cnt_q == SHAMT_W'(1)) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      alu_ctrl_q   <= C_PASS;
      shift_step_q <= 1'b0;
      out_last_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      alu_ctrl_q   <= alu_ctrl_d;
      shift_step_q <= shift_step_d;
      out_last_q   <= out_last_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign shift_step_o = shift_step_q;
  assign out_last_o   = out_last_q;
  assign illegal_o    = illegal_q;
  assign busy_o       = (state_q == SHIFT);

endmodule
